// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for one shared ALU, with a two-stage
// pipeline (operand register -> result register) and valid/ready on every port.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module alu #(
  parameter int W = 32
) (
  input  logic [5:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] result,
  output logic         err
);
  typedef enum logic [5:0] {
    OP_ADD  = 6'b011001,
    OP_SUB  = 6'b011011,
    OP_AND  = 6'b011101,
    OP_OR   = 6'b011111,
    OP_XOR  = 6'b100001,
    OP_SLT  = 6'b100011,
    OP_SLTU = 6'b100101,
    OP_SLL  = 6'b100111,
    OP_SRL  = 6'b101001,
    OP_SRA  = 6'b101011
  } alu_op_e;

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    result = '0;
    err    = 1'b0;
    case (op)
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_SLT:  result = {{(W-1){1'b0}}, $signed(a) < $signed(b)};
      OP_SLTU: result = {{(W-1){1'b0}}, a < b};
      OP_SLL:  result = a << b[4:0];
      OP_SRL:  result = a >> b[4:0];
      OP_SRA:  result = $signed(a) >>> b[4:0];
      default: err    = 1'b1;
    endcase
  end
endmodule

module alu_arbiter #(
  parameter int TAG_W = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_req0_valid,
  output logic                   o_req0_ready,
  input  logic [5:0]             i_req0_op,
  input  logic [`DATA_WIDTH-1:0] i_req0_a,
  input  logic [`DATA_WIDTH-1:0] i_req0_b,
  input  logic [TAG_W-1:0]       i_req0_tag,
  input  logic                   i_req1_valid,
  output logic                   o_req1_ready,
  input  logic [5:0]             i_req1_op,
  input  logic [`DATA_WIDTH-1:0] i_req1_a,
  input  logic [`DATA_WIDTH-1:0] i_req1_b,
  input  logic [TAG_W-1:0]       i_req1_tag,
  output logic                   o_rsp_valid,
  input  logic                   i_rsp_ready,
  output logic [`DATA_WIDTH-1:0] o_rsp_data,
  output logic                   o_rsp_id,
  output logic [TAG_W-1:0]       o_rsp_tag,
  output logic                   o_rsp_err,
  output logic                   o_busy
);
  localparam int DW = `DATA_WIDTH;

  logic             s1_valid, s1_id;
  logic [5:0]       s1_op;
  logic [DW-1:0]    s1_a, s1_b;
  logic [TAG_W-1:0] s1_tag;
  logic             s2_valid, s2_id, s2_err;
  logic [DW-1:0]    s2_data;
  logic [TAG_W-1:0] s2_tag;
  logic             last_grant;

  logic          s2_free, s1_adv, s1_free;
  logic          grant, accept0, accept1, accept;
  logic [DW-1:0] alu_result;
  logic          alu_err;

  assign s2_free = !s2_valid || i_rsp_ready;
  assign s1_adv  = s1_valid && s2_free;
  assign s1_free = !s1_valid || s1_adv;

  always_comb begin
    grant = 1'b0;
    if (i_req0_valid && i_req1_valid) grant = !last_grant;
    else if (i_req1_valid)            grant = 1'b1;
  end

  // Readies are masked while reset is held so nothing looks accepted then.
  assign accept0 = i_rst_n && s1_free && i_req0_valid && !grant;
  assign accept1 = i_rst_n && s1_free && i_req1_valid && grant;
  assign accept  = accept0 || accept1;

  assign o_req0_ready = accept0;
  assign o_req1_ready = accept1;

  alu #(.W(DW)) u_alu (
    .op     (s1_op),
    .a      (s1_a),
    .b      (s1_b),
    .result (alu_result),
    .err    (alu_err)
  );

  // NOTE: sequential state uses non-blocking assignments only; payload
  // registers are reset too so the response outputs read zero after reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_valid   <= 1'b0;
      s1_id      <= 1'b0;
      s1_op      <= '0;
      s1_a       <= '0;
      s1_b       <= '0;
      s1_tag     <= '0;
      s2_valid   <= 1'b0;
      s2_id      <= 1'b0;
      s2_err     <= 1'b0;
      s2_data    <= '0;
      s2_tag     <= '0;
      last_grant <= 1'b1;
    end else begin
      if (accept) begin
        s1_id      <= accept1;
        s1_op      <= accept1 ? i_req1_op  : i_req0_op;
        s1_a       <= accept1 ? i_req1_a   : i_req0_a;
        s1_b       <= accept1 ? i_req1_b   : i_req0_b;
        s1_tag     <= accept1 ? i_req1_tag : i_req0_tag;
        last_grant <= accept1;
      end
      s1_valid <= accept || (s1_valid && !s1_adv);

      if (s1_adv) begin
        s2_data <= alu_result;
        s2_err  <= alu_err;
        s2_id   <= s1_id;
        s2_tag  <= s1_tag;
      end
      s2_valid <= s1_adv || (s2_valid && !i_rsp_ready);
    end
  end

  assign o_rsp_valid = s2_valid;
  assign o_rsp_data  = s2_data;
  assign o_rsp_id    = s2_id;
  assign o_rsp_tag   = s2_tag;
  assign o_rsp_err   = s2_err;
  assign o_busy      = s1_valid || s2_valid;
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter: arbitration, pipeline timing,
// backpressure, opcode coverage, illegal opcodes and mid-flight reset.
`timescale 1ns/1ps

module tb_alu_arbiter;
  localparam logic [5:0] ADD = 6'b011001, SUB = 6'b011011, AND = 6'b011101,
                         OR = 6'b011111, XOR = 6'b100001, SLT = 6'b100011,
                         SLTU = 6'b100101, SLL = 6'b100111, SRL = 6'b101001,
                         SRA = 6'b101011;

  logic        i_clk = 1'b0, i_rst_n = 1'b0;
  logic        i_req0_valid, i_req1_valid, i_rsp_ready;
  logic [5:0]  i_req0_op, i_req1_op;
  logic [31:0] i_req0_a, i_req0_b, i_req1_a, i_req1_b;
  logic [3:0]  i_req0_tag, i_req1_tag;
  logic        o_req0_ready, o_req1_ready, o_rsp_valid, o_rsp_id, o_rsp_err, o_busy;
  logic [31:0] o_rsp_data;
  logic [3:0]  o_rsp_tag;

  int total = 0;
  int bad   = 0;

  always #5 i_clk = ~i_clk;

  alu_arbiter #(.TAG_W(4)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_req0_valid(i_req0_valid), .o_req0_ready(o_req0_ready), .i_req0_op(i_req0_op),
    .i_req0_a(i_req0_a), .i_req0_b(i_req0_b), .i_req0_tag(i_req0_tag),
    .i_req1_valid(i_req1_valid), .o_req1_ready(o_req1_ready), .i_req1_op(i_req1_op),
    .i_req1_a(i_req1_a), .i_req1_b(i_req1_b), .i_req1_tag(i_req1_tag),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready), .o_rsp_data(o_rsp_data),
    .o_rsp_id(o_rsp_id), .o_rsp_tag(o_rsp_tag), .o_rsp_err(o_rsp_err), .o_busy(o_busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_rsp(input string tag, input logic [31:0] data, input logic id,
                           input logic [3:0] t, input logic err);
    check({tag, ".valid"}, {31'b0, o_rsp_valid}, 32'd1);
    check({tag, ".data"},  o_rsp_data, data);
    check({tag, ".id"},    {31'b0, o_rsp_id}, {31'b0, id});
    check({tag, ".tag"},   {28'b0, o_rsp_tag}, {28'b0, t});
    check({tag, ".err"},   {31'b0, o_rsp_err}, {31'b0, err});
  endtask

  task automatic check_ready(input string tag, input logic r0, input logic r1);
    check({tag, ".ready0"}, {31'b0, o_req0_ready}, {31'b0, r0});
    check({tag, ".ready1"}, {31'b0, o_req1_ready}, {31'b0, r1});
  endtask

  task automatic set_req(input int port, input logic v, input logic [5:0] op,
                         input logic [31:0] a, input logic [31:0] b, input logic [3:0] t);
    if (port == 0) begin
      i_req0_valid = v; i_req0_op = op; i_req0_a = a; i_req0_b = b; i_req0_tag = t;
    end else begin
      i_req1_valid = v; i_req1_op = op; i_req1_a = a; i_req1_b = b; i_req1_tag = t;
    end
  endtask

  task automatic idle_inputs();
    set_req(0, 1'b0, '0, '0, '0, '0);
    set_req(1, 1'b0, '0, '0, '0, '0);
  endtask

  task automatic do_reset();
    @(negedge i_clk);
    i_rst_n = 1'b0;
    idle_inputs();
    i_rsp_ready = 1'b1;
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;
  endtask

  // Issue one op on a single port with the consumer always ready and check
  // the response two edges after the accepting edge.
  task automatic single_op(input string tag, input int port, input logic [5:0] op,
                           input logic [31:0] a, input logic [31:0] b, input logic [3:0] t,
                           input logic [31:0] exp_data, input logic exp_err);
    @(negedge i_clk);
    i_rsp_ready = 1'b1;
    set_req(port, 1'b1, op, a, b, t);
    #1 check_ready({tag, ".acc"}, port == 0, port == 1);
    @(negedge i_clk);
    idle_inputs();
    check({tag, ".mid_valid"}, {31'b0, o_rsp_valid}, 32'd0);
    check({tag, ".mid_busy"},  {31'b0, o_busy}, 32'd1);
    @(negedge i_clk);
    check_rsp(tag, exp_data, port[0], t, exp_err);
  endtask

  initial begin
    idle_inputs();
    i_rsp_ready = 1'b1;

    // Reset state, with a requester valid to prove ready is held low.
    #2;
    i_req0_valid = 1'b1;
    #1;
    check("rst.rsp_valid", {31'b0, o_rsp_valid}, 32'd0);
    check("rst.busy",      {31'b0, o_busy}, 32'd0);
    check("rst.data",      o_rsp_data, 32'd0);
    check("rst.tag",       {28'b0, o_rsp_tag}, 32'd0);
    check_ready("rst", 1'b0, 1'b0);
    do_reset();

    // Tie rotation: grants 0,1,0,1 and responses 7 / 0xFF alternate.
    for (int k = 0; k < 6; k++) begin
      @(negedge i_clk);
      if (k < 4) begin
        set_req(0, 1'b1, SUB, 32'd10, 32'd3, 4'd1);
        set_req(1, 1'b1, XOR, 32'hF0, 32'h0F, 4'd2);
      end else begin
        idle_inputs();
      end
      #1;
      if (k < 4) check_ready($sformatf("tie%0d", k), (k % 2) == 0, (k % 2) == 1);
      if (k < 2) check($sformatf("tie%0d.rsp_valid", k), {31'b0, o_rsp_valid}, 32'd0);
      else if ((k % 2) == 0) check_rsp($sformatf("tie%0d", k), 32'd7, 1'b0, 4'd1, 1'b0);
      else check_rsp($sformatf("tie%0d", k), 32'hFF, 1'b1, 4'd2, 1'b0);
    end
    @(negedge i_clk);
    check("tie.drained", {31'b0, o_busy}, 32'd0);

    // Single ops over a spread of opcodes plus the illegal code.
    single_op("add",  0, ADD,  32'd5,          32'd7,          4'd3, 32'd12,         1'b0);
    single_op("sll",  1, SLL,  32'd1,          32'd4,          4'd4, 32'h10,         1'b0);
    single_op("srl",  0, SRL,  32'h8000_0000,  32'd4,          4'd5, 32'h0800_0000,  1'b0);
    single_op("sra",  1, SRA,  32'h8000_0000,  32'd4,          4'd6, 32'hF800_0000,  1'b0);
    single_op("slt",  0, SLT,  32'hFFFF_FFFF,  32'd1,          4'd7, 32'd1,          1'b0);
    single_op("sltu", 1, SLTU, 32'hFFFF_FFFF,  32'd1,          4'd8, 32'd0,          1'b0);
    single_op("or",   0, OR,   32'h30,         32'h03,         4'hA, 32'h33,         1'b0);
    single_op("ill",  1, 6'b000000, 32'd1,     32'd1,          4'd9, 32'd0,          1'b1);
    @(negedge i_clk);
    check("ill.consumed", {31'b0, o_rsp_valid}, 32'd0);

    // Backpressure: three ops from req1 while the consumer is stalled.
    do_reset();
    @(negedge i_clk);
    i_rsp_ready = 1'b0;
    set_req(1, 1'b1, ADD, 32'd1, 32'd10, 4'd0);
    #1 check_ready("bp0", 1'b0, 1'b1);
    @(negedge i_clk);
    set_req(1, 1'b1, ADD, 32'd2, 32'd10, 4'd1);
    #1 check_ready("bp1", 1'b0, 1'b1);
    @(negedge i_clk);
    set_req(1, 1'b1, ADD, 32'd3, 32'd10, 4'd2);
    for (int k = 0; k < 3; k++) begin
      #1 check_ready($sformatf("bp_stall%0d", k), 1'b0, 1'b0);
      check_rsp($sformatf("bp_hold%0d", k), 32'd11, 1'b1, 4'd0, 1'b0);
      check($sformatf("bp_busy%0d", k), {31'b0, o_busy}, 32'd1);
      @(negedge i_clk);
    end
    i_rsp_ready = 1'b1;
    #1 check_ready("bp_release", 1'b0, 1'b1);
    @(negedge i_clk);
    idle_inputs();
    check_rsp("bp_r1", 32'd12, 1'b1, 4'd1, 1'b0);
    @(negedge i_clk);
    check_rsp("bp_r2", 32'd13, 1'b1, 4'd2, 1'b0);
    @(negedge i_clk);
    check("bp.empty", {31'b0, o_busy}, 32'd0);

    // Stall must not rotate priority: pending grant belongs to requester 0.
    do_reset();
    @(negedge i_clk);
    i_rsp_ready = 1'b0;
    set_req(1, 1'b1, SUB, 32'd9, 32'd4, 4'd1);
    @(negedge i_clk);
    set_req(1, 1'b1, AND, 32'hC, 32'hA, 4'd2);
    @(negedge i_clk);
    set_req(0, 1'b1, OR,  32'h30, 32'h03, 4'd5);
    set_req(1, 1'b1, SLT, 32'hFFFF_FFFF, 32'd1, 4'd6);
    for (int k = 0; k < 5; k++) begin
      #1 check_ready($sformatf("st_stall%0d", k), 1'b0, 1'b0);
      @(negedge i_clk);
    end
    i_rsp_ready = 1'b1;
    #1 check_ready("st_release", 1'b1, 1'b0);
    check_rsp("st_r0", 32'd5, 1'b1, 4'd1, 1'b0);
    @(negedge i_clk);
    #1 check_ready("st_next", 1'b0, 1'b1);
    check_rsp("st_r1", 32'd8, 1'b1, 4'd2, 1'b0);
    @(negedge i_clk);
    idle_inputs();
    check_rsp("st_r2", 32'h33, 1'b0, 4'd5, 1'b0);
    @(negedge i_clk);
    check_rsp("st_r3", 32'd1, 1'b1, 4'd6, 1'b0);

    // Reset with both stages full.
    do_reset();
    @(negedge i_clk);
    i_rsp_ready = 1'b0;
    set_req(0, 1'b1, ADD, 32'd1, 32'd2, 4'd3);
    @(negedge i_clk);
    @(negedge i_clk);
    check("mf.busy_full", {31'b0, o_busy}, 32'd1);
    check("mf.valid_full", {31'b0, o_rsp_valid}, 32'd1);
    i_req1_valid = 1'b1;
    i_rst_n = 1'b0;
    #1;
    check("mf.rsp_valid", {31'b0, o_rsp_valid}, 32'd0);
    check("mf.busy",      {31'b0, o_busy}, 32'd0);
    check("mf.data",      o_rsp_data, 32'd0);
    check_ready("mf.rst", 1'b0, 1'b0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    i_rsp_ready = 1'b1;
    set_req(0, 1'b1, ADD, 32'd4, 32'd4, 4'd1);
    set_req(1, 1'b1, ADD, 32'd6, 32'd6, 4'd2);
    #1 check_ready("mf.first_tie", 1'b1, 1'b0);
    @(negedge i_clk);
    idle_inputs();
    @(negedge i_clk);
    check_rsp("mf.rsp", 32'd8, 1'b0, 4'd1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one instance of the existing alu between two requesters (e.g. integer issue slot and address-generation/CSR helper), so no second ALU is needed.
- Round-robin arbitration with valid/ready handshakes on both request ports and on the single response port.
- Two-stage pipeline (operand register -> result register) with full backpressure, so the ALU sits between registers and throughput is 1 op/cycle.

Parameters:
- TAG_W, 4, width of the opaque requester tag carried alongside each operation.
- DATA_WIDTH (macro from definitions.vh, 32), operand/result width; not overridable per instance.

Ports:
- i_clk  input  1  clock, all state on rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_req0_valid  input  1  requester 0 has an op.
- o_req0_ready  output  1  requester 0 op accepted this cycle when valid & ready.
- i_req0_op  input  6  ALU opcode (alu encoding: ADD 6'b011001, SUB 6'b011011, AND 6'b011101, OR 6'b011111, XOR 6'b100001, SLT 6'b100011, SLTU 6'b100101, SLL 6'b100111, SRL 6'b101001, SRA 6'b101011).
- i_req0_a, i_req0_b  input  DATA_WIDTH  operands.
- i_req0_tag  input  TAG_W  tag returned with result.
- i_req1_valid, o_req1_ready, i_req1_op, i_req1_a, i_req1_b, i_req1_tag: same as requester 0.
- o_rsp_valid  output  1  result available.
- i_rsp_ready  input  1  consumer takes result when valid & ready.
- o_rsp_data  output  DATA_WIDTH  ALU result.
- o_rsp_id  output  1  requester index (0/1) that issued the op.
- o_rsp_tag  output  TAG_W  tag of issuing request.
- o_rsp_err  output  1  opcode was not one of the ten legal codes (data is 0).
- o_busy  output  1  S1 or S2 holds a valid op.

Behaviour:
- State: S1 {valid, op, a, b, id, tag}; S2 {valid, data, id, tag, err}; last_grant (1 bit).
- Reset (async, i_rst_n=0): S1.valid=0, S2.valid=0, last_grant=1 (requester 0 wins first tie). Outputs: o_rsp_valid=0, o_req0_ready=0, o_req1_ready=0, o_busy=0, o_rsp_data/tag/id/err=0. In-flight ops discarded. Release is synchronous to i_clk in the sense that no state changes before the first rising edge.
- s2_free = !S2.valid | i_rsp_ready; s1_adv = S1.valid & s2_free; s1_free = !S1.valid | s1_adv.
- Arbitration (combinational):
  - Only one valid: that requester is granted.
  - Both valid: grant = !last_grant.
  - o_reqN_ready = grant==N & reqN_valid & s1_free; never both ready in the same cycle.
  - o_reqN_ready may depend on i_rsp_ready combinationally (documented path); it never depends on its own port's op/a/b/tag.
- Accept: on a handshake, S1 loads op/a/b/tag and id=N, and last_grant=N. last_grant changes only on an accepted handshake; a grant lost to a stall does not rotate priority.
- ALU: the alu instance reads S1.op/a/b. err = opcode not in legal set.
- Advance: on s1_adv, S2 loads {alu result, S1.id, S1.tag, err}, and S1.valid clears unless a new accept happens in the same cycle.
- S2.valid clears on a response handshake unless refilled in the same cycle.
- Latency: handshake at edge N -> o_rsp_valid at edge N+2 when unstalled. Sustained 1 op/cycle when i_rsp_ready=1.
- Backpressure: with i_rsp_ready=0, S2 holds, then S1 holds, then both readies drop. At most 2 ops in flight.
- Outputs o_rsp_* are stable while o_rsp_valid=1 and i_rsp_ready=0.
- Requester holding valid without ready must keep its fields stable; the arbiter does not latch anything until the handshake.
- o_busy = S1.valid | S2.valid.

Test Plan:
- Single op: req0 ADD a=5,b=7,tag=3, rsp_ready=1 -> accepted at edge 0; edge 2: rsp_valid=1, data=12, id=0, tag=3, err=0.
- Tie rotation: both valid every cycle (req0 SUB 10-3, req1 XOR 0xF0^0x0F), rsp_ready=1 -> grants 0,1,0,1; responses 7,0xFF alternate with ids 0,1, one per cycle.
- Backpressure: rsp_ready=0 while issuing 3 ops from req1 -> 2 accepted, readies then 0, o_busy=1. Raise rsp_ready -> results return in order, third op accepted the same cycle.
- Stall does not rotate: both valid, rsp_ready=0 with pipe full for 5 cycles -> on release, requester 0 (pending grant) is accepted first.
- Illegal op 6'b000000 with a=1,b=1 -> rsp data=0, err=1, correct tag/id.
- Reset mid-flight: assert i_rst_n=0 with S1 and S2 full -> immediately rsp_valid=0, readies=0, o_busy=0. After release, the first tie goes to requester 0.
